// File: rtl/alarm_pkg.sv
// Shared definitions for the car-alarm buzzer path: state encoding and the
// default timing constants that the detector bench also relies on.
package alarm_pkg;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_QUALIFY_ENC  = 3'd1;
    localparam logic [2:0] ST_BEEP_ON_ENC  = 3'd2;
    localparam logic [2:0] ST_BEEP_OFF_ENC = 3'd3;
    localparam logic [2:0] ST_SNOOZE_ENC   = 3'd4;
    localparam logic [2:0] ST_DONE_ENC     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE_ENC,
        S_QUALIFY  = ST_QUALIFY_ENC,
        S_BEEP_ON  = ST_BEEP_ON_ENC,
        S_BEEP_OFF = ST_BEEP_OFF_ENC,
        S_SNOOZE   = ST_SNOOZE_ENC,
        S_DONE     = ST_DONE_ENC
    } alarm_state_t;

    localparam int DEF_QUAL_CYC     = 4;
    localparam int DEF_BEEP_ON_CYC  = 8;
    localparam int DEF_BEEP_OFF_CYC = 8;
    localparam int DEF_MAX_BEEPS    = 16;
    localparam int DEF_SNOOZE_CYC   = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_phase_timer.sv
// Loadable down-counter shared by all timed alarm states; expired is high
// once the loaded count has run down to zero.
module alarm_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at zero so expired stays asserted until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Qualifies the detector's sAlarm, pulses the buzzer in bounded bursts and
// handles driver acknowledge/snooze. Outputs decode registered state only.
module alarm_buzzer_ctrl
    import alarm_pkg::*;
#(
    parameter int QUAL_CYC     = DEF_QUAL_CYC,
    parameter int BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
    parameter int BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
    parameter int MAX_BEEPS    = DEF_MAX_BEEPS,
    parameter int SNOOZE_CYC   = DEF_SNOOZE_CYC,
    parameter int CW           = $clog2(MAX_BEEPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          sAlarm,
    input  logic          ack,
    output logic          buzzer,
    output logic          alarm_active,
    output logic          timed_out,
    output logic [CW-1:0] beep_count
);

    localparam int TMAX = max_int(max_int(QUAL_CYC, BEEP_ON_CYC),
                                  max_int(BEEP_OFF_CYC, SNOOZE_CYC));
    localparam int TW   = $clog2(TMAX + 1);

    // The timer holds cycles remaining after the current one, so a state
    // lasting N cycles loads N-1. The first qualifying sample is taken in
    // IDLE, leaving QUAL_CYC-1 cycles in QUALIFY.
    localparam logic [TW-1:0] LD_QUAL   = TW'(QUAL_CYC - 2);
    localparam logic [TW-1:0] LD_ON     = TW'(BEEP_ON_CYC - 1);
    localparam logic [TW-1:0] LD_OFF    = TW'(BEEP_OFF_CYC - 1);
    localparam logic [TW-1:0] LD_SNOOZE = TW'(SNOOZE_CYC - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_BEEPS);

    alarm_state_t  state_q, state_d;
    logic [CW-1:0] beep_count_q, beep_count_d;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_expired;

    alarm_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Priority: enable, then sAlarm, then ack, then timer expiry.
    always_comb begin
        state_d      = state_q;
        beep_count_d = beep_count_q;
        if (!enable) begin
            state_d      = S_IDLE;
            beep_count_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    beep_count_d = '0;
                    if (sAlarm) state_d = S_QUALIFY;
                end
                S_QUALIFY: begin
                    if (!sAlarm) begin
                        state_d      = S_IDLE;
                        beep_count_d = '0;
                    end else if (timer_expired) begin
                        state_d = S_BEEP_ON;
                    end
                end
                S_BEEP_ON: begin
                    if (!sAlarm) begin
                        state_d      = S_IDLE;
                        beep_count_d = '0;
                    end else if (ack) begin
                        state_d = S_SNOOZE;
                    end else if (timer_expired) begin
                        state_d      = S_BEEP_OFF;
                        beep_count_d = beep_count_q + CW'(1);
                    end
                end
                S_BEEP_OFF: begin
                    if (!sAlarm) begin
                        state_d      = S_IDLE;
                        beep_count_d = '0;
                    end else if (ack) begin
                        state_d = S_SNOOZE;
                    end else if (timer_expired) begin
                        state_d = (beep_count_q == MAX_CNT) ? S_DONE : S_BEEP_ON;
                    end
                end
                S_SNOOZE: begin
                    if (!sAlarm) begin
                        state_d      = S_IDLE;
                        beep_count_d = '0;
                    end else if (timer_expired) begin
                        state_d      = S_BEEP_ON;
                        beep_count_d = '0;
                    end
                end
                S_DONE: begin
                    if (!sAlarm) begin
                        state_d      = S_IDLE;
                        beep_count_d = '0;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    beep_count_d = '0;
                end
            endcase
        end
    end

    // Every state change reloads the phase timer with the new state's length.
    always_comb begin
        timer_load = (state_d != state_q);
        timer_val  = '0;
        unique case (state_d)
            S_QUALIFY:  timer_val = LD_QUAL;
            S_BEEP_ON:  timer_val = LD_ON;
            S_BEEP_OFF: timer_val = LD_OFF;
            S_SNOOZE:   timer_val = LD_SNOOZE;
            default:    timer_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beep_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beep_count_q <= beep_count_d;
        end
    end

    assign buzzer       = (state_q == S_BEEP_ON);
    assign alarm_active = (state_q == S_QUALIFY) || (state_q == S_BEEP_ON) ||
                          (state_q == S_BEEP_OFF) || (state_q == S_SNOOZE);
    assign timed_out    = (state_q == S_DONE);
    assign beep_count   = beep_count_q;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Scoreboard bench for alarm_buzzer_ctrl: stimulus queues hand-derived
// expectations, a monitor pops and compares one entry per clock.
module tb_alarm_buzzer_ctrl;

    localparam int Q    = 4;
    localparam int ON   = 8;
    localparam int OFF  = 8;
    localparam int MAXB = 16;
    localparam int SNZ  = 64;
    localparam int CW   = $clog2(MAXB + 1);

    typedef struct {
        logic          buzz;
        logic          act;
        logic          tout;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          sAlarm;
    logic          ack;
    logic          buzzer;
    logic          alarm_active;
    logic          timed_out;
    logic [CW-1:0] beep_count;

    exp_t expQ[$];
    int   checkCount;
    int   errorCount;

    alarm_buzzer_ctrl #(
        .QUAL_CYC     (Q),
        .BEEP_ON_CYC  (ON),
        .BEEP_OFF_CYC (OFF),
        .MAX_BEEPS    (MAXB),
        .SNOOZE_CYC   (SNZ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sAlarm       (sAlarm),
        .ack          (ack),
        .buzzer       (buzzer),
        .alarm_active (alarm_active),
        .timed_out    (timed_out),
        .beep_count   (beep_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (buzzer !== e.buzz || alarm_active !== e.act ||
            timed_out !== e.tout || beep_count !== e.cnt) begin
            errorCount++;
            $display("[TB] FAIL %s t=%0t: got buzz=%b act=%b to=%b cnt=%0d, want buzz=%b act=%b to=%b cnt=%0d",
                     e.name, $time, buzzer, alarm_active, timed_out, beep_count,
                     e.buzz, e.act, e.tout, e.cnt);
        end
    endtask

    function automatic exp_t mkExp(input logic b, input logic a, input logic t,
                                   input int c, input string nm);
        exp_t e;
        e.buzz = b;
        e.act  = a;
        e.tout = t;
        e.cnt  = CW'(c);
        e.name = nm;
        return e;
    endfunction

    // Expected outputs after edge n of a continuously high sAlarm burst,
    // with edge 0 being the first high sample taken in IDLE.
    function automatic exp_t burstExp(input int n, input string nm);
        int m, ph, b;
        if (n < Q - 1) return mkExp(1'b0, 1'b1, 1'b0, 0, nm);
        if (n >= Q - 1 + MAXB * (ON + OFF)) return mkExp(1'b0, 1'b0, 1'b1, MAXB, nm);
        m  = n - (Q - 1);
        ph = m % (ON + OFF);
        b  = m / (ON + OFF);
        return mkExp(ph < ON, 1'b1, 1'b0, b + ((ph >= ON) ? 1 : 0), nm);
    endfunction

    // Drive inputs at a falling edge, queue the response expected after the
    // following rising edge, then return at the next falling edge.
    task automatic applyStimulus(input logic en, input logic sa, input logic ak,
                                 input exp_t e);
        enable = en;
        sAlarm = sa;
        ack    = ak;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "idle"));
    endtask

    // Monitor: one comparison per queued expectation, just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        sAlarm = 1'b0;
        ack    = 1'b0;
        #3;
        checkOutput(mkExp(1'b0, 1'b0, 1'b0, 0, "reset_state"));
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        // Glitch: three high samples then low never reaches the buzzer.
        for (int n = 0; n < 3; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "glitch_qual"));
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "glitch_reject"));
        idleCycles(2);

        // Full burst to timeout; ack in DONE must be ignored.
        for (int n = 0; n <= 270; n++)
            applyStimulus(1'b1, 1'b1, (n >= 262 && n <= 265), burstExp(n, "burst"));
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "done_exit"));
        idleCycles(2);

        // Ack mid beep 3, held for a while, then snooze expiry restarts the burst.
        for (int n = 0; n <= 36; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "pre_snooze"));
        for (int n = 37; n <= 100; n++)
            applyStimulus(1'b1, 1'b1, (n <= 45), mkExp(1'b0, 1'b1, 1'b0, 2, "snooze_hold"));
        for (int n = 101; n <= 108; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, mkExp(1'b1, 1'b1, 1'b0, 0, "resume_on"));
        for (int n = 109; n <= 110; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1, "resume_off"));
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "resume_drop"));
        idleCycles(2);

        // Ack ignored in QUALIFY; ack during BEEP_OFF; sAlarm drop in SNOOZE.
        for (int n = 0; n <= 27; n++)
            applyStimulus(1'b1, 1'b1, (n == 1), burstExp(n, "pre_ack_off"));
        for (int n = 28; n <= 39; n++)
            applyStimulus(1'b1, 1'b1, (n == 28), mkExp(1'b0, 1'b1, 1'b0, 2, "snooze_off"));
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "snooze_drop"));
        idleCycles(2);

        // Ack on the same edge as the first BEEP_ON expiry: not counted.
        for (int n = 0; n <= 10; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "pre_collide"));
        for (int n = 11; n <= 20; n++)
            applyStimulus(1'b1, 1'b1, (n == 11), mkExp(1'b0, 1'b1, 1'b0, 0, "ack_expiry"));
        applyStimulus(1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "collide_drop"));
        idleCycles(2);

        // sAlarm low together with ack resolves to IDLE.
        for (int n = 0; n <= 4; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "pre_simul"));
        applyStimulus(1'b1, 1'b0, 1'b1, mkExp(1'b0, 1'b0, 1'b0, 0, "drop_and_ack"));
        idleCycles(2);

        // Asynchronous reset while the buzzer is on, then full requalification.
        for (int n = 0; n <= 5; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "pre_reset"));
        rst_n = 1'b0;
        #1;
        checkOutput(mkExp(1'b0, 1'b0, 1'b0, 0, "async_reset"));
        applyStimulus(1'b1, 1'b1, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "in_reset"));
        rst_n = 1'b1;
        for (int n = 0; n <= 4; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "requalify"));
        idleCycles(2);

        // enable low during BEEP_OFF, then re-enable restarts qualification.
        for (int n = 0; n <= 12; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "pre_disable"));
        applyStimulus(1'b0, 1'b1, 1'b0, mkExp(1'b0, 1'b0, 1'b0, 0, "disable"));
        for (int n = 0; n <= 4; n++)
            applyStimulus(1'b1, 1'b1, 1'b0, burstExp(n, "reenable"));
        idleCycles(2);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alarm_buzzer_ctrl.md
Name: alarm_buzzer_ctrl

Overview:
- Downstream consumer of the car-alarm detector's sAlarm output (detector combines sLuz, sPrta, sIgn).
- Qualifies sAlarm against glitches, drives a pulsed buzzer, supports driver acknowledge/snooze, and auto-silences after a bounded number of beeps.
- Sits between the alarm detector and the buzzer driver pin.

Parameters:
- QUAL_CYC, 4, consecutive sampled-high cycles of sAlarm required to start beeping (legal range 2 and up).
- BEEP_ON_CYC, 8, buzzer-high cycles per beep (1 and up).
- BEEP_OFF_CYC, 8, buzzer-low cycles between beeps (1 and up).
- MAX_BEEPS, 16, complete beeps before auto-silence (1 and up).
- SNOOZE_CYC, 64, silent cycles after ack (1 and up).
- CW, computed as $clog2(MAX_BEEPS+1), width of beep_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  system armed; low forces IDLE.
- sAlarm  in  1  raw alarm condition from the detector.
- ack  in  1  driver acknowledge, level-sampled.
- buzzer  out  1  buzzer drive.
- alarm_active  out  1  high in QUALIFY, BEEP_ON, BEEP_OFF and SNOOZE.
- timed_out  out  1  high in DONE.
- beep_count  out  CW  beeps completed in the current burst.

Behaviour:
- Reset: rst_n low sets state=IDLE and clears all counters immediately. Outputs go to buzzer=0, alarm_active=0, timed_out=0, beep_count=0. Reset mid-beep cuts the buzzer immediately, with no clock required.
- Outputs are decoded from registered state and counters only (Moore); no combinational input-to-output path.
- States are IDLE, QUALIFY, BEEP_ON, BEEP_OFF, SNOOZE, DONE. One phase counter is shared by all timed states and reloads on every state change.
- Priority in every state, highest first: enable=0, then sAlarm=0, then ack, then timer expiry. The first two send the FSM to IDLE; each clears beep_count.
- IDLE:
  - enable&sAlarm moves to QUALIFY with cnt=1.
- QUALIFY:
  - sAlarm high with cnt==QUAL_CYC-1 moves to BEEP_ON.
  - Otherwise cnt increments.
  - Result: sAlarm high on edges k..k+QUAL_CYC-1 gives buzzer=1 after edge k+QUAL_CYC-1.
  - A single low sample returns the FSM to IDLE.
  - ack is ignored in QUALIFY.
- BEEP_ON:
  - buzzer=1 for exactly BEEP_ON_CYC cycles, then moves to BEEP_OFF.
  - beep_count increments on that transition.
- BEEP_OFF:
  - buzzer=0 for exactly BEEP_OFF_CYC cycles.
  - Then moves to DONE if beep_count==MAX_BEEPS, else back to BEEP_ON.
- ack in BEEP_ON or BEEP_OFF:
  - Moves to SNOOZE on the next edge, and buzzer drops that edge.
  - beep_count holds its value.
  - A partial beep interrupted by ack is not counted.
- SNOOZE:
  - buzzer=0 for SNOOZE_CYC cycles; ack held high during SNOOZE has no further effect.
  - On expiry, if sAlarm is still high: move to BEEP_ON with beep_count=0 (fresh burst; no re-qualification).
  - sAlarm=0 at any point moves to IDLE.
- DONE:
  - buzzer=0 and timed_out=1; beep_count holds MAX_BEEPS.
  - ack is ignored.
  - Exits only when sAlarm=0 or enable=0, going to IDLE.
- beep_count never exceeds MAX_BEEPS.
- An ack arriving on the same edge as a BEEP_ON→BEEP_OFF expiry wins: the FSM goes to SNOOZE and the count does not increment.
- Simultaneous sAlarm=0 and ack resolves to IDLE.
- Inputs are synchronous to clk; no synchronizers are included in this block.

Decomposition:
- Shared package alarm_pkg holds:
  - the state encoding as localparams (3-bit, IDLE=0);
  - default timing constants, shared with the detector bench.
- One sub-module, alarm_phase_timer, is natural: a loadable down-counter with a load pulse, load value and expired flag, sized to the largest of QUAL_CYC, BEEP_ON_CYC, BEEP_OFF_CYC and SNOOZE_CYC.
- The FSM and beep counter stay in alarm_buzzer_ctrl.

Test Plan:
- Glitch reject: enable=1, sAlarm high for 3 cycles then low → buzzer stays 0, alarm_active high for 3 cycles then 0, beep_count=0.
- Qualify and beep: sAlarm held high from cycle 0 → buzzer=1 from after edge 3.
  - Then alternating 8 high, 8 low.
  - beep_count reads 1 after edge 11 and 2 after edge 27.
- Timeout: sAlarm held high with MAX_BEEPS=16 → after 16 beeps (4+16*16 edges) timed_out=1, buzzer=0, beep_count=16.
  - Stays so while sAlarm is high; sAlarm=0 → IDLE with all outputs 0.
- Snooze: ack pulsed mid-BEEP_ON of beep 3 → buzzer=0 next edge, beep_count=2 held.
  - After 64 cycles, with sAlarm still high, BEEP_ON resumes with beep_count=0.
  - A repeat with sAlarm dropped during snooze gives IDLE.
- Async reset: assert rst_n=0 between clock edges while buzzer=1 → buzzer, alarm_active and beep_count go to 0 immediately.
  - After release with sAlarm high, the full QUAL_CYC qualification is required again.
- Enable override: enable=0 during BEEP_OFF → IDLE next edge.
  - Re-enable with sAlarm high restarts QUALIFY with beep_count=0.
